// File: rtl/capture_ctrl.sv
`timescale 1ns/1ps
// capture_ctrl: circular-buffer sample capture controller.
// Generates a clk/2 ADC clock and a decimated sample strobe. It prefills the
// sample RAM, waits for a qualified trigger edge (or force_trig), records
// trig_pos post-trigger samples, and reports the last written address.
// Optional build macro CAPTURE_AUTO_TRIG_EN adds a 2^20-1 clk auto-trigger
// timeout while waiting for a trigger.
module capture_ctrl #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          trig1,
    input  logic          trig2,
    input  logic          arm,
    input  logic          trig_src,
    input  logic          trig_pos_edge,
    input  logic [AW-1:0] trig_pos,
    input  logic [3:0]    decimator,
    input  logic          force_trig,
    output logic          adc_clk,
    output logic          rclk,
    output logic          en,
    output logic          we,
    output logic [AW-1:0] addr,
    output logic          busy,
    output logic          capture_done,
    output logic [AW-1:0] trig_addr
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PREFILL   = 3'd1,
        WAIT_TRIG = 3'd2,
        POST      = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam logic [AW-1:0] A_ZERO  = {AW{1'b0}};
    localparam logic [AW-1:0] A_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   S_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

    state_t        state_r;
    logic          adc_clk_r;
    logic [15:0]   dec_cnt_r;
    logic [1:0]    t1_sync_r;
    logic [1:0]    t2_sync_r;
    logic          t1_prev_r;
    logic          t2_prev_r;
    logic [AW-1:0] addr_r;
    logic          wr_r;
    logic          busy_r;
    logic          done_r;
    logic [AW-1:0] trig_addr_r;
    logic [AW:0]   smp_cnt_r;
    logic [AW-1:0] post_cnt_r;
    logic [AW-1:0] tp_r;
    logic          src_r;
    logic          pol_r;
    logic [3:0]    dec_r;

    logic [15:0]   dec_mask_s;
    logic          strobe_s;
    logic          sel_now_s;
    logic          sel_prev_s;
    logic          edge_s;
    logic          timeout_s;
    logic          trig_s;
    logic          arm_ok_s;
    logic [AW-1:0] tp_eff_s;
    logic [AW:0]   prefill_len_s;

    // Strobe, trigger qualification and arm-time parameter decode.
    always_comb begin
        dec_mask_s    = (16'd1 << dec_r) - 16'd1;
        strobe_s      = adc_clk_r && (dec_cnt_r == dec_mask_s);
        sel_now_s     = src_r ? t2_sync_r[1] : t1_sync_r[1];
        sel_prev_s    = src_r ? t2_prev_r : t1_prev_r;
        edge_s        = (sel_now_s != sel_prev_s) && (sel_now_s == pol_r);
        trig_s        = edge_s || force_trig || timeout_s;
        arm_ok_s      = arm && (state_r != DONE);
        prefill_len_s = DEPTH_C - {1'b0, tp_r};
        if (trig_pos == A_ZERO) begin
            tp_eff_s = A_ONE;
        end else begin
            tp_eff_s = trig_pos;
        end
    end

`ifdef CAPTURE_AUTO_TRIG_EN
    logic [19:0] to_cnt_r;

    // Count clk cycles spent in WAIT_TRIG; saturating value acts as a forced trigger.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_r <= 20'd0;
        end else if (state_r == WAIT_TRIG) begin
            to_cnt_r <= to_cnt_r + 20'd1;
        end else begin
            to_cnt_r <= 20'd0;
        end
    end

    assign timeout_s = (to_cnt_r == 20'hFFFFF);
`else
    assign timeout_s = 1'b0;
`endif

    // Free-running clk/2 ADC clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adc_clk_r <= 1'b0;
        end else begin
            adc_clk_r <= ~adc_clk_r;
        end
    end

    // Decimation counter: steps once per ADC period, wraps after each strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_cnt_r <= 16'd0;
        end else if (arm_ok_s) begin
            dec_cnt_r <= 16'd0;
        end else if (adc_clk_r) begin
            dec_cnt_r <= strobe_s ? 16'd0 : (dec_cnt_r + 16'd1);
        end else begin
            dec_cnt_r <= dec_cnt_r;
        end
    end

    // Two-flop synchronizers on the comparator inputs plus a copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t1_sync_r <= 2'b00;
            t2_sync_r <= 2'b00;
            t1_prev_r <= 1'b0;
            t2_prev_r <= 1'b0;
        end else begin
            t1_sync_r <= {t1_sync_r[0], trig1};
            t2_sync_r <= {t2_sync_r[0], trig2};
            t1_prev_r <= t1_sync_r[1];
            t2_prev_r <= t2_sync_r[1];
        end
    end

    // Capture sequencer: write strobes, address walk, trigger and completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            addr_r      <= A_ZERO;
            wr_r        <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            trig_addr_r <= A_ZERO;
            smp_cnt_r   <= {(AW+1){1'b0}};
            post_cnt_r  <= A_ZERO;
            tp_r        <= A_ZERO;
            src_r       <= 1'b0;
            pol_r       <= 1'b0;
            dec_r       <= 4'd0;
        end else if (arm_ok_s) begin
            state_r    <= PREFILL;
            addr_r     <= A_ZERO;
            wr_r       <= 1'b0;
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
            smp_cnt_r  <= {(AW+1){1'b0}};
            post_cnt_r <= A_ZERO;
            tp_r       <= tp_eff_s;
            src_r      <= trig_src;
            pol_r      <= trig_pos_edge;
            dec_r      <= decimator;
        end else begin
            wr_r   <= 1'b0;
            done_r <= 1'b0;
            // The write presented this cycle used addr_r; advance for the next one.
            if (wr_r) begin
                addr_r <= addr_r + A_ONE;
            end else begin
                addr_r <= addr_r;
            end
            case (state_r)
                IDLE: begin
                    state_r <= IDLE;
                end
                PREFILL: begin
                    if (strobe_s) begin
                        wr_r      <= 1'b1;
                        smp_cnt_r <= smp_cnt_r + S_ONE;
                        if ((smp_cnt_r + S_ONE) == prefill_len_s) begin
                            state_r <= WAIT_TRIG;
                        end else begin
                            state_r <= PREFILL;
                        end
                    end else begin
                        state_r <= PREFILL;
                    end
                end
                WAIT_TRIG: begin
                    wr_r <= strobe_s;
                    if (trig_s) begin
                        state_r    <= POST;
                        post_cnt_r <= tp_r;
                    end else begin
                        state_r <= WAIT_TRIG;
                    end
                end
                POST: begin
                    if (strobe_s) begin
                        wr_r       <= 1'b1;
                        post_cnt_r <= post_cnt_r - A_ONE;
                        if (post_cnt_r == A_ONE) begin
                            state_r     <= DONE;
                            done_r      <= 1'b1;
                            busy_r      <= 1'b0;
                            trig_addr_r <= addr_r;
                        end else begin
                            state_r <= POST;
                        end
                    end else begin
                        state_r <= POST;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign adc_clk      = adc_clk_r;
    assign rclk         = clk;
    assign en           = wr_r;
    assign we           = wr_r;
    assign addr         = addr_r;
    assign busy         = busy_r;
    assign capture_done = done_r;
    assign trig_addr    = trig_addr_r;

endmodule
